// File: rtl/adsr_pkg.sv
// Shared types and sizes for the ADSR envelope generator.
package adsr_pkg;

  localparam int unsigned ENV_W  = 16;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned RATE_W = 8;
  localparam int unsigned ST_W   = 3;

  localparam logic [ENV_W-1:0] ENV_MAX = 16'hFFFF;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/adsr_env_if.sv
// Control/parameter inputs and envelope outputs of adsr_env.
interface adsr_env_if;
  import adsr_pkg::*;

  logic              sample_en;
  logic              gate;
  logic              trig;
  logic              mute;
  logic [RATE_W-1:0] adsr_ai;
  logic [RATE_W-1:0] adsr_di;
  logic [RATE_W-1:0] adsr_s;
  logic [RATE_W-1:0] adsr_ri;
  logic [OUT_W-1:0]  env_out;
  logic [ST_W-1:0]   state;
  logic              active;

  modport master (
    output sample_en, gate, trig, mute, adsr_ai, adsr_di, adsr_s, adsr_ri,
    input  env_out, state, active
  );

  modport slave (
    input  sample_en, gate, trig, mute, adsr_ai, adsr_di, adsr_s, adsr_ri,
    output env_out, state, active
  );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous pin inputs, resets to 0.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: key gate / one-shot trigger to a 16-bit envelope
// that steps once per audio-sample strobe; top byte drives the amplitude.
module adsr_env
  import adsr_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  adsr_env_if.slave bus
);

  logic             w_gate_s;
  adsr_state_e      r_state;
  adsr_state_e      w_state_nxt;
  logic [ENV_W-1:0] r_env;
  logic [ENV_W-1:0] w_env_nxt;
  logic             r_gq;
  logic             r_pend;
  logic             r_oneshot;
  logic             r_active;
  logic             w_oneshot_nxt;
  logic             w_g;
  logic             w_pend_eff;
  logic             w_rise;
  logic [ENV_W-1:0] w_s16;
  logic [ENV_W:0]   w_att_sum;
  logic [ENV_W:0]   w_dec_lim;

  sync2 #(.W(1)) u_gate_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.gate),
    .o_q   (w_gate_s)
  );

  assign w_g        = w_gate_s | r_oneshot;
  assign w_pend_eff = r_pend | bus.trig;
  assign w_rise     = (w_g & ~r_gq) | w_pend_eff;
  assign w_s16      = {bus.adsr_s, 8'h00};
  assign w_att_sum  = (ENV_W+1)'(r_env) + (ENV_W+1)'(bus.adsr_ai);
  assign w_dec_lim  = (ENV_W+1)'(w_s16) + (ENV_W+1)'(bus.adsr_di);

  // Next state and envelope for the coming strobe: retrigger > gate low > progression.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_rise) begin
      w_state_nxt = ATTACK;
    end else if (!w_g && (r_state inside {ATTACK, DECAY, SUSTAIN})) begin
      w_state_nxt = RELEASE;
    end else begin
      case (r_state)
        IDLE: w_env_nxt = '0;
        ATTACK: begin
          if (w_att_sum >= (ENV_W+1)'(ENV_MAX) || bus.adsr_ai == '0) begin
            w_env_nxt   = ENV_MAX;
            w_state_nxt = DECAY;
          end else begin
            w_env_nxt = w_att_sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          if ((ENV_W+1)'(r_env) <= w_dec_lim || bus.adsr_di == '0) begin
            w_env_nxt   = w_s16;
            w_state_nxt = SUSTAIN;
          end else begin
            w_env_nxt = r_env - ENV_W'(bus.adsr_di);
          end
        end
        SUSTAIN: w_env_nxt = w_s16;
        RELEASE: begin
          if (r_env <= ENV_W'(bus.adsr_ri) || bus.adsr_ri == '0) begin
            w_env_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_env_nxt = r_env - ENV_W'(bus.adsr_ri);
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // A trigger always wins; otherwise the one-shot gate ends when DECAY is left.
  always_comb begin
    w_oneshot_nxt = r_oneshot;
    if (w_pend_eff) begin
      w_oneshot_nxt = 1'b1;
    end else if (r_state == DECAY && w_state_nxt != DECAY) begin
      w_oneshot_nxt = 1'b0;
    end
  end

  // Mute overrides the strobe and clears all edge/trigger history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_env     <= '0;
      r_gq      <= 1'b0;
      r_pend    <= 1'b0;
      r_oneshot <= 1'b0;
      r_active  <= 1'b0;
    end else if (bus.mute) begin
      r_state   <= IDLE;
      r_env     <= '0;
      r_gq      <= 1'b0;
      r_pend    <= 1'b0;
      r_oneshot <= 1'b0;
      r_active  <= 1'b0;
    end else if (bus.sample_en) begin
      r_state   <= w_state_nxt;
      r_env     <= w_env_nxt;
      r_oneshot <= w_oneshot_nxt;
      r_gq      <= w_gate_s | w_oneshot_nxt;
      r_pend    <= 1'b0;
      r_active  <= (w_state_nxt != IDLE);
    end else if (bus.trig) begin
      r_pend <= 1'b1;
    end
  end

  assign bus.env_out = r_env[ENV_W-1 -: OUT_W];
  assign bus.state   = r_state;
  assign bus.active  = r_active;

endmodule
